// File: rtl/multicycle_cu.sv
// rtl/multicycle_cu.sv - multi-cycle RV32I control unit with memory handshake and timeout
module multicycle_cu #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] I,
    input  logic        Z,
    input  logic        mem_ready,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  PCsrc,
    output logic        mem_req,
    output logic        memRW,
    output logic        regW,
    output logic        ALUsrc,
    output logic        sub,
    output logic [2:0]  ALUop,
    output logic [2:0]  IMMs,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           cur;
    logic [CNT_W-1:0] cnt;
    logic             gap;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic is_r, is_i, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic legal, req_state, timeout, in_op;

    assign opcode = I[6:0];
    assign func3  = I[14:12];
    assign func7  = I[31:25];

    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign is_br    = (opcode == 7'b1100011);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign is_lui   = (opcode == 7'b0110111);
    assign is_auipc = (opcode == 7'b0010111);

    // Only BEQ/BNE are supported among branches.
    assign legal = (is_r | is_i | is_load | is_store | is_jal | is_jalr | is_lui | is_auipc)
                 | (is_br & (func3[2:1] == 2'b00));

    // The cycle after a timeout is a FETCH with the request dropped.
    assign req_state = ((cur == FETCH) && !gap) || (cur == MEM);
    assign timeout   = (MEM_TIMEOUT != 0) && req_state && !mem_ready && (cnt == LIMIT);
    assign in_op     = (cur == EXEC) || (cur == MEM) || (cur == WB);
    assign state     = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= FETCH;
            cnt <= '0;
            gap <= 1'b0;
        end else begin
            gap <= 1'b0;
            if (req_state && !mem_ready && !timeout)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            case (cur)
                FETCH: begin
                    if (!gap) begin
                        if (mem_ready)
                            cur <= DECODE;
                        else if (timeout)
                            gap <= 1'b1;
                    end
                end
                DECODE: cur <= legal ? EXEC : FETCH;
                EXEC: begin
                    if (is_load || is_store)
                        cur <= MEM;
                    else if (is_br)
                        cur <= FETCH;
                    else
                        cur <= WB;
                end
                MEM: begin
                    if (mem_ready) begin
                        cur <= is_load ? WB : FETCH;
                    end else if (timeout) begin
                        cur <= FETCH;
                        gap <= 1'b1;
                    end
                end
                WB:      cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

    always_comb begin
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        PCsrc   = 2'b00;
        mem_req = 1'b0;
        memRW   = 1'b0;
        regW    = 1'b0;
        ALUsrc  = 1'b0;
        sub     = 1'b0;
        ALUop   = 3'b000;
        IMMs    = 3'b000;
        wb_sel  = 2'b00;
        illegal = 1'b0;
        bus_err = 1'b0;
        if (!rst) begin
            if (cur == FETCH && !gap) begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
                bus_err = timeout;
            end
            if (cur == DECODE)
                illegal = !legal;
            // ALU/immediate controls stay stable from EXEC through MEM and WB.
            if (in_op) begin
                if (is_r) begin
                    ALUop = func3;
                    sub   = (func7 != 7'd0);
                end
                if (is_i) begin
                    ALUop  = func3;
                    ALUsrc = 1'b1;
                    sub    = (func3 == 3'b101) && (func7 == 7'b0100000);
                end
                if (is_load || is_store) begin
                    ALUsrc = 1'b1;
                    IMMs   = is_store ? 3'b001 : 3'b000;
                end
                if (is_br) begin
                    sub  = 1'b1;
                    IMMs = 3'b010;
                end
                if (is_jal)
                    IMMs = 3'b100;
                if (is_jalr)
                    ALUsrc = 1'b1;
                if (is_lui || is_auipc)
                    IMMs = 3'b011;
                if (is_auipc)
                    ALUsrc = 1'b1;
            end
            if (cur == EXEC) begin
                if (is_br) begin
                    PCsrc = 2'b01;
                    pc_we = func3[0] ? !Z : Z;
                end
                if (is_jal) begin
                    PCsrc = 2'b01;
                    pc_we = 1'b1;
                end
                if (is_jalr) begin
                    PCsrc = 2'b10;
                    pc_we = 1'b1;
                end
            end
            if (cur == MEM) begin
                mem_req = 1'b1;
                memRW   = is_store;
                bus_err = timeout;
            end
            if (cur == WB) begin
                regW = 1'b1;
                if (is_load)
                    wb_sel = 2'b01;
                else if (is_jal || is_jalr)
                    wb_sel = 2'b10;
                else if (is_lui)
                    wb_sel = 2'b11;
                else
                    wb_sel = 2'b00;
            end
        end
    end

endmodule
